led_pwm_fader: RTL and testbench

Downstream output stage for the LED blink counter: accepts the 4-bit LED pattern the counter produces and drives the board LEDs through per-channel PWM. Each LED fades in or out over roughly one second instead of switching hard. Sits between the pattern generator and the `led` pins, all in the 125 MHz fabric clock domain.

---
 rtl/led_pwm_fader_pkg.sv | 30 +++
 rtl/led_pwm_fader_channel.sv | 77 +++++++
 rtl/led_pwm_fader.sv | 77 +++++++
 tb/tb_led_pwm_fader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_pwm_fader_pkg.sv
//------------------------------------------------------------------------------
// Module   : led_pkg
// Brief    : Shared constants and types for the LED pattern / PWM fader path.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package led_pkg;

    localparam int NUM_LEDS     = 4;
    localparam int CLK_HZ       = 125_000_000;

    localparam int PWM_BITS_DEF = 8;
    localparam int PWM_DIV_DEF  = 4;
    // 255 steps of this length make a full fade last about one second at CLK_HZ.
    localparam int FADE_DIV_DEF = 488_281;

    typedef enum logic [1:0] {
        FADE_HOLD = 2'd0,
        FADE_UP   = 2'd1,
        FADE_DOWN = 2'd2
    } fade_dir_e;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pwm_fader_channel.sv
//------------------------------------------------------------------------------
// Module   : led_pwm_channel
// Brief    : One LED channel: target/level registers, +-1 fade step, PWM compare.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_pwm_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                on,
    input  logic                fade_tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                busy
);

    localparam logic [PWM_BITS-1:0] MAX_LEVEL = '1;

    logic [PWM_BITS-1:0] target_q, target_d;
    logic [PWM_BITS-1:0] level_q,  level_d;
    logic                led_q,    led_d;
    fade_dir_e           dir;

    always_comb begin
        dir      = FADE_HOLD;
        target_d = target_q;
        level_d  = level_q;
        led_d    = 1'b0;

        if (level_q < target_q) begin
            dir = FADE_UP;
        end else if (level_q > target_q) begin
            dir = FADE_DOWN;
        end

        if (load) begin
            target_d = on ? MAX_LEVEL : '0;
        end

        // Direction comes from the pre-edge target, so a coincident load only
        // takes effect from the following tick.
        if (fade_tick) begin
            case (dir)
                FADE_UP:   level_d = level_q + PWM_BITS'(1);
                FADE_DOWN: level_d = level_q - PWM_BITS'(1);
                default:   level_d = level_q;
            endcase
        end

        // Full scale forces the output on so MAX has no one-count dark gap.
        led_d = (level_q == MAX_LEVEL) || (level_q > pwm_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
            level_q  <= '0;
            led_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            level_q  <= level_d;
            led_q    <= led_d;
        end
    end

    assign led  = led_q;
    assign busy = (level_q != target_q);

endmodule

`default_nettype wire

// File: rtl/led_pwm_fader.sv
//------------------------------------------------------------------------------
// Module   : led_pwm_fader
// Brief    : Fades each board LED toward the requested on/off pattern via PWM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_pwm_fader
    import led_pkg::*;
#(
    parameter int NUM_LEDS = led_pkg::NUM_LEDS,
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PWM_DIV  = PWM_DIV_DEF,
    parameter int FADE_DIV = FADE_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_LEDS-1:0] pattern_in,
    input  logic                pattern_valid,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy
);

    localparam int PRE_W  = cnt_width(PWM_DIV);
    localparam int FADE_W = cnt_width(FADE_DIV);

    localparam logic [PRE_W-1:0]  PWM_PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [FADE_W-1:0] FADE_PRE_LAST = FADE_W'(FADE_DIV - 1);

    logic [PRE_W-1:0]    pwm_pre_q,  pwm_pre_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,  pwm_cnt_d;
    logic [FADE_W-1:0]   fade_pre_q, fade_pre_d;
    logic                pwm_wrap;
    logic                fade_tick;
    logic [NUM_LEDS-1:0] ch_busy;

    // Both prescalers free-run; pattern loads never disturb their phase.
    always_comb begin
        pwm_wrap   = (pwm_pre_q == PWM_PRE_LAST);
        fade_tick  = (fade_pre_q == FADE_PRE_LAST);
        pwm_pre_d  = pwm_wrap  ? '0 : pwm_pre_q + PRE_W'(1);
        pwm_cnt_d  = pwm_wrap  ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        fade_pre_d = fade_tick ? '0 : fade_pre_q + FADE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_pre_q  <= '0;
            pwm_cnt_q  <= '0;
            fade_pre_q <= '0;
        end else begin
            pwm_pre_q  <= pwm_pre_d;
            pwm_cnt_q  <= pwm_cnt_d;
            fade_pre_q <= fade_pre_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (pattern_valid),
            .on        (pattern_in[i]),
            .fade_tick (fade_tick),
            .pwm_cnt   (pwm_cnt_q),
            .led       (led[i]),
            .busy      (ch_busy[i])
        );
    end

    assign busy = |ch_busy;

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
//------------------------------------------------------------------------------
// Module   : tb_led_pwm_fader
// Brief    : Directed scoreboard bench for led_pwm_fader (PWM_BITS=4, PWM_DIV=1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_pwm_fader;

    localparam logic [1:0] K_SNAP  = 2'd0;
    localparam logic [1:0] K_DUTY  = 2'd1;
    localparam logic [1:0] K_SBUSY = 2'd2;

    typedef struct packed {
        logic [1:0]      kind;
        logic [3:0]      led;
        logic [3:0]      mask;
        logic            chk_busy;
        logic            busy;
        logic [4:0]      count;
        logic [8*12-1:0] tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] pat_in = '0;
    logic       p_valid = 1'b0;
    logic [3:0] s_pat = '0;
    logic       s_valid = 1'b0;
    logic [3:0] dut_led, s_led;
    logic       dut_busy, s_busy;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc;
    int   duty_cnt;

    led_pwm_fader #(
        .NUM_LEDS (4), .PWM_BITS (4), .PWM_DIV (1), .FADE_DIV (2)
    ) dut (
        .clk (clk), .rst_n (rst_n), .pattern_in (pat_in), .pattern_valid (p_valid),
        .led (dut_led), .busy (dut_busy)
    );

    // Long fade step so a level can be held still while its duty is measured.
    led_pwm_fader #(
        .NUM_LEDS (4), .PWM_BITS (4), .PWM_DIV (1), .FADE_DIV (64)
    ) dut_slow (
        .clk (clk), .rst_n (rst_n), .pattern_in (s_pat), .pattern_valid (s_valid),
        .led (s_led), .busy (s_busy)
    );

    always #5 clk = ~clk;

    // Edge index since reset release: fade ticks land on even edges (multiples of 64 for dut_slow).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at(input int e);
        int guard = 0;
        while (cyc < e && guard < 2000) begin
            step(1);
            guard++;
        end
    endtask

    task automatic push(input logic [8*12-1:0] tag, input logic [1:0] kind,
                        input logic [3:0] l, input logic [3:0] m,
                        input logic cb, input logic b, input logic [4:0] cnt);
        exp_t e;
        e.kind = kind; e.led = l; e.mask = m; e.chk_busy = cb;
        e.busy = b; e.count = cnt; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic load(input logic [3:0] pat, input int m, input int r, input bit slow);
        while (((cyc + 1) % m) != r) step(1);
        if (slow) begin s_pat = pat; s_valid = 1'b1; end
        else      begin pat_in = pat; p_valid = 1'b1; end
        @(posedge clk);
        #1;
        p_valid = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                case (e.kind)
                    K_SNAP: begin
                        if (((dut_led & e.mask) !== (e.led & e.mask)) ||
                            (e.chk_busy && (dut_busy !== e.busy))) begin
                            failures++;
                            $display("FAIL %s: got led=%b busy=%b, want led=%b (mask %b) busy=%b (checked=%b)",
                                     e.tag, dut_led, dut_busy, e.led, e.mask, e.busy, e.chk_busy);
                        end
                    end
                    K_DUTY: begin
                        duty_cnt = int'(s_led[0]);
                        repeat (15) begin
                            @(negedge clk);
                            duty_cnt += int'(s_led[0]);
                        end
                        if (duty_cnt != int'(e.count)) begin
                            failures++;
                            $display("FAIL %s: got %0d high of 16, want %0d", e.tag, duty_cnt, e.count);
                        end
                    end
                    default: begin
                        if (s_busy !== e.busy) begin
                            failures++;
                            $display("FAIL %s: got busy=%b, want %b", e.tag, s_busy, e.busy);
                        end
                    end
                endcase
            end
        end
    end

    initial begin : stimulus
        int n;
        int m;
        int guard;

        step(3);
        rst_n = 1'b1;
        at(10);  push("idle_a", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);
        at(20);  push("idle_b", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);

        // Fade in channel 0: 15 ticks on edges n+1, n+3 .. n+29.
        load(4'b0001, 2, 1, 1'b0); n = cyc;
        push("fin_load", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b1, 5'd0);
        at(n + 28); push("fin_busy", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(n + 29); push("fin_done", K_SNAP, 4'b0000, 4'b1110, 1'b1, 1'b0, 5'd0);
        for (int j = 31; j < 47; j++) begin
            at(n + j); push("fin_full", K_SNAP, 4'b0001, 4'b1111, 1'b1, 1'b0, 5'd0);
        end

        load(4'b0000, 2, 1, 1'b0); n = cyc;
        at(n + 28); push("fout_busy", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(n + 29); push("fout_done", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd0);
        at(n + 31); push("fout_dark", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);

        // Reversal at level 9: nine steps back down, ticks on m+1 .. m+17.
        load(4'b0001, 2, 1, 1'b0); n = cyc;
        at(n + 17);
        load(4'b0000, 2, 1, 1'b0); m = cyc;
        push("rev_load", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(m + 16); push("rev_busy", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(m + 17); push("rev_done", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd0);
        for (int j = 18; j < 22; j++) begin
            at(m + j); push("rev_dark", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);
        end

        // Load on a tick edge with pwm_cnt phase 14: first real step lands on n+2.
        load(4'b1111, 16, 14, 1'b0); n = cyc;
        at(n + 1);  push("coin_n1", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b1, 5'd0);
        at(n + 2);  push("coin_n2", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b1, 5'd0);
        at(n + 3);  push("coin_lvl1", K_SNAP, 4'b1111, 4'b1111, 1'b1, 1'b1, 5'd0);
        at(n + 29); push("coin_busy", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(n + 30); push("coin_done", K_SNAP, 4'b1111, 4'b1111, 1'b1, 1'b0, 5'd0);

        load(4'b0000, 2, 1, 1'b0); n = cyc;
        at(n + 29); push("clr_done", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd0);
        at(n + 31); push("clr_dark", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);

        // Independent channels: 1010 until level 4, then 0110.
        load(4'b1010, 2, 1, 1'b0); n = cyc;
        at(n + 7);
        load(4'b0110, 2, 1, 1'b0);
        at(n + 31); push("ind_a", K_SNAP, 4'b0010, 4'b1011, 1'b1, 1'b1, 5'd0);
        at(n + 33); push("ind_b", K_SNAP, 4'b0010, 4'b1011, 1'b1, 1'b1, 5'd0);
        at(n + 36); push("ind_busy", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(n + 37); push("ind_done", K_SNAP, 4'b0000, 4'b0000, 1'b1, 1'b0, 5'd0);
        at(n + 38); push("ind_final", K_SNAP, 4'b0110, 4'b1111, 1'b1, 1'b0, 5'd0);

        // Asynchronous reset while led=0110 and busy=1; checked before the next edge.
        load(4'b1001, 2, 1, 1'b0);
        step(1);
        rst_n = 1'b0;
        push("rst_async", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);
        step(3);
        rst_n = 1'b1;

        // dut_slow: ticks at 64,128,..; level 6 after edge 384 holds until 448.
        load(4'b0001, 64, 5, 1'b1);
        for (int j = 1; j <= 10; j++) begin
            at(10 * j); push("post_rst", K_SNAP, 4'b0000, 4'b1111, 1'b1, 1'b0, 5'd0);
        end
        at(389);
        load(4'b0000, 1, 0, 1'b1);
        at(391); push("slow_busy", K_SBUSY, 4'b0000, 4'b0000, 1'b1, 1'b1, 5'd0);
        at(399); push("duty_l6", K_DUTY, 4'b0000, 4'b0000, 1'b0, 1'b0, 5'd6);
        at(420);

        guard = 0;
        while (sb.size() > 0 && guard < 100) begin
            step(1);
            guard++;
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
